// File: rtl/inst_fetcher.sv
// RV32I fetch front-end: one outstanding I-cache request, J/B target prediction, and an instruction queue.
// Define IFETCH_BTFN_EN to predict only backward B-type branches as taken. Forward branches then fall through.
module inst_fetcher #(
   parameter logic [31:0] RESET_PC     = 32'h0,
   parameter int          IQ_DEPTH_LOG = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush_in,
   input  logic [31:0] flush_pc_in,
   input  logic        jalr_resolve_valid_in,
   input  logic [31:0] jalr_target_in,
   output logic        icache_req_valid_out,
   output logic [31:0] icache_req_addr_out,
   input  logic        icache_resp_valid_in,
   input  logic [31:0] icache_resp_inst_in,
   output logic        iq_valid_out,
   input  logic        iq_ready_in,
   output logic [31:0] iq_inst_out,
   output logic [31:0] iq_pc_out,
   output logic [31:0] iq_pred_pc_out,
   output logic        iq_pred_taken_out
);

   localparam int DEPTH = 1 << IQ_DEPTH_LOG;

   localparam logic [1:0] S_FETCH     = 2'd0;
   localparam logic [1:0] S_WAIT      = 2'd1;
   localparam logic [1:0] S_JALR_WAIT = 2'd2;
   localparam logic [1:0] S_DROP      = 2'd3;

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE = 1;
   localparam logic [IQ_DEPTH_LOG:0]   CNT_ONE = 1;

   logic [1:0]              state_q, state_d;
   logic [31:0]             pc_q, pc_d;
   logic [IQ_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [IQ_DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [IQ_DEPTH_LOG:0]   count_q, count_d;

   logic [31:0] inst_mem_q  [DEPTH];
   logic [31:0] pc_mem_q    [DEPTH];
   logic [31:0] pred_mem_q  [DEPTH];
   logic        taken_mem_q [DEPTH];

   logic        iq_full, iq_nonempty;
   logic        req_fire, push, pop;
   logic [6:0]  opcode;
   logic [31:0] pred_pc;
   logic        pred_taken;

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   // count never exceeds DEPTH, so its MSB alone marks a full queue
   assign iq_full     = count_q[IQ_DEPTH_LOG];
   assign iq_nonempty = |count_q;
   assign opcode      = icache_resp_inst_in[6:0];

   // rst_in gates the pulse so nothing is requested while the cache itself is held in reset
   assign req_fire = rst_in & rdy_in & ~flush_in & (state_q == S_FETCH) & ~iq_full;
   assign push     = rdy_in & ~flush_in & (state_q == S_WAIT) & icache_resp_valid_in;
   assign pop      = rdy_in & ~flush_in & iq_nonempty & iq_ready_in;

   always_comb begin
      pred_pc    = pc_q + 32'd4;
      pred_taken = 1'b0;
      unique case (opcode)
         OP_JAL: begin
            pred_pc    = pc_q + imm_j(icache_resp_inst_in);
            pred_taken = 1'b1;
         end
         OP_BR: begin
`ifdef IFETCH_BTFN_EN
            // inst[31] is the sign bit of immB: only backward branches are predicted taken
            if (icache_resp_inst_in[31]) begin
               pred_pc    = pc_q + imm_b(icache_resp_inst_in);
               pred_taken = 1'b1;
            end
`else
            pred_pc    = pc_q + imm_b(icache_resp_inst_in);
            pred_taken = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (rdy_in) begin
         if (flush_in) begin
            pc_d     = flush_pc_in;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            // a request still in flight must be drained before fetching again
            if ((state_q == S_WAIT || state_q == S_DROP) && !icache_resp_valid_in)
               state_d = S_DROP;
            else
               state_d = S_FETCH;
         end else begin
            unique case (state_q)
               S_FETCH: if (!iq_full) state_d = S_WAIT;
               S_WAIT: begin
                  if (icache_resp_valid_in) begin
                     pc_d    = pred_pc;
                     state_d = (opcode == OP_JALR) ? S_JALR_WAIT : S_FETCH;
                  end
               end
               S_JALR_WAIT: begin
                  if (jalr_resolve_valid_in) begin
                     pc_d    = jalr_target_in;
                     state_d = S_FETCH;
                  end
               end
               S_DROP: if (icache_resp_valid_in) state_d = S_FETCH;
               default: state_d = S_FETCH;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
               2'b10:   count_d = count_q + CNT_ONE;
               2'b01:   count_d = count_q - CNT_ONE;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         inst_mem_q[wr_ptr_q]  <= icache_resp_inst_in;
         pc_mem_q[wr_ptr_q]    <= pc_q;
         pred_mem_q[wr_ptr_q]  <= pred_pc;
         taken_mem_q[wr_ptr_q] <= pred_taken;
      end
   end

   assign icache_req_valid_out = req_fire;
   assign icache_req_addr_out  = {pc_q[31:2], 2'b00};

   // head fields read as zero when empty so the storage needs no reset
   assign iq_valid_out      = iq_nonempty;
   assign iq_inst_out       = iq_nonempty ? inst_mem_q[rd_ptr_q]  : 32'h0;
   assign iq_pc_out         = iq_nonempty ? pc_mem_q[rd_ptr_q]    : 32'h0;
   assign iq_pred_pc_out    = iq_nonempty ? pred_mem_q[rd_ptr_q]  : 32'h0;
   assign iq_pred_taken_out = iq_nonempty ? taken_mem_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: directed programs, a behavioural I-cache, and a monitor comparing requests and queue pops.
`timescale 1ns/1ps
module tb_inst_fetcher;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pred;
      logic        taken;
   } ent_t;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] JAL16   = 32'h0100_006F;
   localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
   localparam logic [31:0] BEQ_P8  = 32'h0000_0463;
   localparam logic [31:0] JALR_X1 = 32'h0000_8067;

   logic        clk = 1'b0;
   logic        rst_n, rdy, flush, jalr_v, resp_v, iq_ready;
   logic [31:0] flush_pc, jalr_t, resp_inst;
   logic        req_v, iq_v, iq_taken;
   logic [31:0] req_addr, iq_inst, iq_pc, iq_pred;

   logic [31:0] exp_req [$];
   ent_t        exp_ent [$];
   logic [31:0] imem [logic [31:0]];

   int vectors = 0;
   int errors  = 0;
   int req_cnt = 0;
   int lat     = 1;
   int base;

   logic        pend;
   int          pcnt;
   logic [31:0] paddr;

   always #5 clk = ~clk;

   inst_fetcher #(.RESET_PC(32'h0), .IQ_DEPTH_LOG(3)) dut (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush), .flush_pc_in(flush_pc),
      .jalr_resolve_valid_in(jalr_v), .jalr_target_in(jalr_t),
      .icache_req_valid_out(req_v), .icache_req_addr_out(req_addr),
      .icache_resp_valid_in(resp_v), .icache_resp_inst_in(resp_inst),
      .iq_valid_out(iq_v), .iq_ready_in(iq_ready), .iq_inst_out(iq_inst), .iq_pc_out(iq_pc),
      .iq_pred_pc_out(iq_pred), .iq_pred_taken_out(iq_taken)
   );

   function automatic logic [31:0] fetch_word(input logic [31:0] a);
      return imem.exists(a) ? imem[a] : NOP;
   endfunction

   task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ent(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pred, input logic taken);
      ent_t e;
      e.inst = inst; e.pc = pc; e.pred = pred; e.taken = taken;
      exp_ent.push_back(e);
   endtask

   task automatic do_flush(input logic [31:0] pc);
      flush = 1'b1; flush_pc = pc;
      cyc(1);
      flush = 1'b0;
   endtask

   task automatic stall_and_clear();
      iq_ready = 1'b0;
      cyc(40);
      imem.delete();
      exp_req.delete();
      exp_ent.delete();
   endtask

   task automatic wait_drain(input string name, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (exp_req.size() == 0 && exp_ent.size() == 0) break;
         cyc(1);
      end
      check(name, 97'(exp_req.size() + exp_ent.size()), 97'd0);
   endtask

   // I-cache: answers each request after lat cycles with the word held in imem
   initial begin
      resp_v = 1'b0; resp_inst = 32'h0; pend = 1'b0; pcnt = 0; paddr = 32'h0;
      forever begin
         @(negedge clk);
         resp_v = 1'b0;
         if (!rst_n) pend = 1'b0;
         else begin
            if (pend) begin
               if (pcnt <= 1) begin
                  resp_v = 1'b1; resp_inst = fetch_word(paddr); pend = 1'b0;
               end else pcnt--;
            end
            if (req_v) begin
               pend = 1'b1; paddr = req_addr; pcnt = lat;
            end
         end
      end
   end

   // monitor: every request and every accepted queue pop is checked against the scoreboard
   initial begin
      logic [31:0] er;
      ent_t        ee;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (flush) check("req_suppressed_in_flush", 97'(req_v), 97'd0);
            if (req_v) begin
               req_cnt++;
               if (exp_req.size() > 0) begin
                  er = exp_req.pop_front();
                  check("req_addr", 97'(req_addr), 97'(er));
               end
            end
            if (iq_v && iq_ready && rdy && !flush && exp_ent.size() > 0) begin
               ee = exp_ent.pop_front();
               check("iq_entry", {iq_inst, iq_pc, iq_pred, iq_taken}, ee);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; flush_pc = 32'h0;
      jalr_v = 1'b0; jalr_t = 32'h0; iq_ready = 1'b1;
      cyc(3);
      check("rst_req_valid", 97'(req_v), 97'd0);
      check("rst_req_addr",  97'(req_addr), 97'd0);
      check("rst_iq_valid",  97'(iq_v), 97'd0);
      check("rst_iq_fields", {iq_inst, iq_pc, iq_pred, iq_taken}, 97'd0);

      // straight-line NOPs from RESET_PC
      exp_req = '{32'h0, 32'h4, 32'h8, 32'hC};
      ent(NOP, 32'h0, 32'h4, 1'b0); ent(NOP, 32'h4, 32'h8, 1'b0);
      ent(NOP, 32'h8, 32'hC, 1'b0); ent(NOP, 32'hC, 32'h10, 1'b0);
      rst_n = 1'b1;
      wait_drain("nop_stream", 60);

      // JAL x0,+16 at 0x20
      stall_and_clear();
      imem[32'h20] = JAL16;
      exp_req = '{32'h20, 32'h30, 32'h34};
      ent(JAL16, 32'h20, 32'h30, 1'b1); ent(NOP, 32'h30, 32'h34, 1'b0); ent(NOP, 32'h34, 32'h38, 1'b0);
      iq_ready = 1'b1;
      do_flush(32'h20);
      check("flush_clears_iq", 97'(iq_v), 97'd0);
      wait_drain("jal", 60);

      // BEQ -8 at 0x40: backward loop
      stall_and_clear();
      imem[32'h40] = BEQ_M8;
      exp_req = '{32'h40, 32'h38, 32'h3C, 32'h40, 32'h38};
      ent(BEQ_M8, 32'h40, 32'h38, 1'b1); ent(NOP, 32'h38, 32'h3C, 1'b0);
      ent(NOP, 32'h3C, 32'h40, 1'b0);    ent(BEQ_M8, 32'h40, 32'h38, 1'b1);
      iq_ready = 1'b1;
      do_flush(32'h40);
      wait_drain("beq_back", 60);

      // BEQ +8 at 0x40: forward branch
      stall_and_clear();
      imem[32'h40] = BEQ_P8;
`ifdef IFETCH_BTFN_EN
      exp_req = '{32'h40, 32'h44, 32'h48};
      ent(BEQ_P8, 32'h40, 32'h44, 1'b0); ent(NOP, 32'h44, 32'h48, 1'b0);
`else
      exp_req = '{32'h40, 32'h48, 32'h4C};
      ent(BEQ_P8, 32'h40, 32'h48, 1'b1); ent(NOP, 32'h48, 32'h4C, 1'b0);
`endif
      iq_ready = 1'b1;
      do_flush(32'h40);
      wait_drain("beq_fwd", 60);

      // JALR at 0x10 stalls fetch until resolved
      stall_and_clear();
      imem[32'h10] = JALR_X1;
      exp_req = '{32'h10};
      ent(JALR_X1, 32'h10, 32'h14, 1'b0);
      iq_ready = 1'b1;
      do_flush(32'h10);
      wait_drain("jalr_entry", 40);
      base = req_cnt;
      cyc(10);
      check("jalr_stall_no_req", 97'(req_cnt - base), 97'd0);
      exp_req = '{32'h100, 32'h104};
      ent(NOP, 32'h100, 32'h104, 1'b0);
      jalr_v = 1'b1; jalr_t = 32'h100;
      cyc(1);
      jalr_v = 1'b0;
      wait_drain("jalr_resolve", 40);

      // flush beats a same-cycle JALR resolve
      stall_and_clear();
      imem[32'h10] = JALR_X1;
      exp_req = '{32'h10};
      ent(JALR_X1, 32'h10, 32'h14, 1'b0);
      iq_ready = 1'b1;
      do_flush(32'h10);
      wait_drain("jalr_entry2", 40);
      cyc(2);
      exp_req = '{32'h500, 32'h504};
      ent(NOP, 32'h500, 32'h504, 1'b0);
      jalr_v = 1'b1; jalr_t = 32'h100;
      do_flush(32'h500);
      jalr_v = 1'b0;
      wait_drain("flush_over_jalr", 40);

      // fill the queue with the decoder stalled
      stall_and_clear();
      base = req_cnt;
      exp_req = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h310, 32'h314, 32'h318, 32'h31C};
      do_flush(32'h300);
      cyc(40);
      check("fill_req_count", 97'(req_cnt - base), 97'd8);
      check("fill_head_pc", 97'(iq_pc), 97'h300);
      cyc(10);
      check("full_no_req", 97'(req_cnt - base), 97'd8);
      exp_req.push_back(32'h320);
      ent(NOP, 32'h300, 32'h304, 1'b0);
      iq_ready = 1'b1;
      cyc(1);
      iq_ready = 1'b0;
      cyc(10);
      check("one_pop_one_req", 97'(req_cnt - base), 97'd9);
      check("pop_drained", 97'(exp_req.size() + exp_ent.size()), 97'd0);

      // rdy low freezes everything, including a flush
      rdy = 1'b0;
      do_flush(32'h700);
      rdy = 1'b1;
      check("rdy_hold_head", 97'(iq_pc), 97'h304);
      exp_req.push_back(32'h324);
      ent(NOP, 32'h304, 32'h308, 1'b0);
      iq_ready = 1'b1;
      cyc(1);
      iq_ready = 1'b0;
      wait_drain("rdy_hold_pop", 10);

      // flush while waiting: late response must be discarded
      stall_and_clear();
      imem[32'h400] = JAL16;
      exp_req = '{32'h400};
      lat = 4;
      iq_ready = 1'b1;
      do_flush(32'h400);
      cyc(1);
      exp_req = '{32'h200, 32'h204};
      ent(NOP, 32'h200, 32'h204, 1'b0);
      lat = 1;
      do_flush(32'h200);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         if (resp_v) begin seen = 1'b1; break; end
      end
      check("late_resp_seen", 97'(seen), 97'd1);
      @(negedge clk);
      check("late_resp_dropped", 97'(iq_v), 97'd0);
      cyc(1);
      wait_drain("after_drop", 40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
